// File: rtl/l0_skew_buffer_if.sv
// Handshake bundle between the core controller (master) and the L0 skew buffer (slave).
// Carries the vector write port, the row-0 drain request and the skewed per-row read side.
interface l0_skew_buffer_if #(
  parameter int row = 8,
  parameter int bw  = 4
);
  logic                wr;
  logic [row*bw-1:0]   in;
  logic                rd;
  logic [row*bw-1:0]   out;
  logic [row-1:0]      out_valid;
  logic                o_full;
  logic                o_ready;
  logic                o_empty;

  modport master (
    output wr, in, rd,
    input  out, out_valid, o_full, o_ready, o_empty
  );

  modport slave (
    input  wr, in, rd,
    output out, out_valid, o_full, o_ready, o_empty
  );
endinterface

// File: rtl/l0_skew_buffer.sv
// L0 input buffer for the MAC array west edge: row-parallel FIFOs sharing one write pointer,
// drained with a one-cycle-per-row stagger to match the array's diagonal dataflow.
module l0_skew_buffer #(
  parameter int row   = 8,
  parameter int bw    = 4,
  parameter int depth = 64
) (
  input logic clk,
  input logic reset,
  l0_skew_buffer_if.slave bus
);
  localparam int aw = $clog2(depth);

  if ((depth < 2) || ((1 << aw) != depth)) begin : g_bad_depth
    $error("l0_skew_buffer: depth must be a power of 2 and >= 2");
  end
  if (row < 2) begin : g_bad_row
    $error("l0_skew_buffer: row must be >= 2");
  end

  logic [bw-1:0]     mem [row][depth];
  logic [aw:0]       wptr;
  logic [aw:0]       rptr [row];
  logic [row-2:0]    rd_chain;
  logic [row-1:0]    rd_d;
  logic [row-1:0]    row_empty;
  logic [row-1:0]    row_full;
  logic [row-1:0]    pop;
  logic              push;
  logic [row*bw-1:0] out_q;
  logic [row-1:0]    valid_q;

  // rd_chain[k] is rd delayed by k+1 cycles; row 0 sees rd directly
  assign rd_d = {rd_chain, bus.rd};

  always_comb begin
    row_empty = '0;
    row_full  = '0;
    for (int r = 0; r < row; r++) begin
      row_empty[r] = (wptr == rptr[r]);
      row_full[r]  = (wptr[aw-1:0] == rptr[r][aw-1:0]) && (wptr[aw] != rptr[r][aw]);
    end
  end

  // The last row always holds the most entries, so any-full equals its full flag
  assign bus.o_full    = |row_full;
  assign bus.o_ready   = ~bus.o_full;
  assign bus.o_empty   = &row_empty;
  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;

  assign push = bus.wr & ~bus.o_full;
  assign pop  = rd_d & ~row_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr     <= '0;
      rd_chain <= '0;
      out_q    <= '0;
      valid_q  <= '0;
      for (int r = 0; r < row; r++) begin
        rptr[r] <= '0;
      end
    end else begin
      if (push) begin
        wptr <= wptr + (aw+1)'(1);
      end
      rd_chain[0] <= bus.rd;
      for (int k = 1; k <= row-2; k++) begin
        rd_chain[k] <= rd_chain[k-1];
      end
      for (int r = 0; r < row; r++) begin
        if (pop[r]) begin
          out_q[r*bw +: bw] <= mem[r][rptr[r][aw-1:0]];
          valid_q[r]        <= 1'b1;
          rptr[r]           <= rptr[r] + (aw+1)'(1);
        end else begin
          valid_q[r]        <= 1'b0;
        end
      end
    end
  end

  // Storage is not cleared on reset; pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (reset && push) begin
      for (int r = 0; r < row; r++) begin
        mem[r][wptr[aw-1:0]] <= bus.in[r*bw +: bw];
      end
    end
  end
endmodule

// File: tb/tb_l0_skew_buffer.sv
// Self-checking bench for l0_skew_buffer: per-cycle reference model (write history plus
// per-row read index) and a table of directed vectors for the single-vector skew case.
module tb_l0_skew_buffer;
  localparam int ROW = 8, BW = 4, DEPTH = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l0_skew_buffer_if #(.row(ROW), .bw(BW)) bus ();
  l0_skew_buffer #(.row(ROW), .bw(BW), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard: every accepted write is pushed; row r consumes from index ridx[r]
  logic [ROW*BW-1:0] hist [$];
  int                ridx [ROW];
  logic [ROW-1:0]    m_rdd;
  logic [ROW*BW-1:0] m_out;
  logic [ROW-1:0]    m_valid;
  int                pops [ROW];
  bit                seen_f;

  typedef struct {
    bit                wr;
    logic [ROW*BW-1:0] data;
    bit                rd;
    logic [ROW-1:0]    ev;
    logic [ROW*BW-1:0] eout;
    bit                eempty;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [ROW*BW-1:0] mkvec(input int k);
    logic [ROW*BW-1:0] v;
    v = '0;
    for (int r = 0; r < ROW; r++) v[r*BW +: BW] = BW'((k + r) % 15);
    return v;
  endfunction

  function automatic int occ(input int r);
    return hist.size() - ridx[r];
  endfunction

  // One clock: drive at negedge, update model at posedge, compare at next negedge
  task automatic cyc(input bit rst_n, input bit w, input logic [ROW*BW-1:0] d, input bit r);
    bit                full_pre, e_empty, e_full;
    logic [ROW-1:0]    eff;
    logic [ROW*BW-1:0] tmp;
    reset   = rst_n;
    bus.wr  = w;
    bus.in  = d;
    bus.rd  = r;
    @(posedge clk);
    if (!rst_n) begin
      hist.delete();
      for (int i = 0; i < ROW; i++) ridx[i] = 0;
      m_rdd   = '0;
      m_out   = '0;
      m_valid = '0;
    end else begin
      full_pre = 1'b0;
      for (int i = 0; i < ROW; i++) if (occ(i) == DEPTH) full_pre = 1'b1;
      eff = {m_rdd[ROW-1:1], r};
      for (int i = 0; i < ROW; i++) begin
        if (eff[i] && occ(i) > 0) begin
          tmp = hist[ridx[i]];
          m_out[i*BW +: BW] = tmp[i*BW +: BW];
          m_valid[i] = 1'b1;
          ridx[i]++;
        end else begin
          m_valid[i] = 1'b0;
        end
      end
      if (w && !full_pre) hist.push_back(d);
      m_rdd = {m_rdd[ROW-2:1], r, 1'b0};
    end
    @(negedge clk);
    e_empty = 1'b1;
    e_full  = 1'b0;
    for (int i = 0; i < ROW; i++) begin
      if (occ(i) != 0) e_empty = 1'b0;
      if (occ(i) == DEPTH) e_full = 1'b1;
    end
    chk("out", 64'(bus.out), 64'(m_out));
    chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
    chk("o_full", 64'(bus.o_full), 64'(e_full));
    chk("o_ready", 64'(bus.o_ready), 64'(!e_full));
    chk("o_empty", 64'(bus.o_empty), 64'(e_empty));
    for (int i = 0; i < ROW; i++) begin
      if (bus.out_valid[i]) begin
        pops[i]++;
        if (bus.out[i*BW +: BW] == 4'hF) seen_f = 1'b1;
      end
    end
  endtask

  task automatic clr_pops();
    for (int i = 0; i < ROW; i++) pops[i] = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t              tbl [10];
    logic [ROW*BW-1:0] snap;
    bit                prev_full, seen7;

    tbl[0] = '{1'b1, 32'h76543210, 1'b0, 8'h00, 32'h00000000, 1'b0};
    tbl[1] = '{1'b0, 32'h0,        1'b1, 8'h01, 32'h00000000, 1'b0};
    tbl[2] = '{1'b0, 32'h0,        1'b0, 8'h02, 32'h00000010, 1'b0};
    tbl[3] = '{1'b0, 32'h0,        1'b0, 8'h04, 32'h00000210, 1'b0};
    tbl[4] = '{1'b0, 32'h0,        1'b0, 8'h08, 32'h00003210, 1'b0};
    tbl[5] = '{1'b0, 32'h0,        1'b0, 8'h10, 32'h00043210, 1'b0};
    tbl[6] = '{1'b0, 32'h0,        1'b0, 8'h20, 32'h00543210, 1'b0};
    tbl[7] = '{1'b0, 32'h0,        1'b0, 8'h40, 32'h06543210, 1'b0};
    tbl[8] = '{1'b0, 32'h0,        1'b0, 8'h80, 32'h76543210, 1'b1};
    tbl[9] = '{1'b0, 32'h0,        1'b0, 8'h00, 32'h76543210, 1'b1};

    seen_f = 1'b0;
    clr_pops();
    reset  = 1'b0;
    bus.wr = 1'b0;
    bus.in = '0;
    bus.rd = 1'b0;
    @(negedge clk);

    // Reset state
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("rst_out", 64'(bus.out), 64'h0);
    chk("rst_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_empty", 64'(bus.o_empty), 64'h1);
    chk("rst_full", 64'(bus.o_full), 64'h0);
    chk("rst_ready", 64'(bus.o_ready), 64'h1);

    // Single vector, one-cycle rd pulse: staggered valid
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, tbl[i].wr, tbl[i].data, tbl[i].rd);
      chk($sformatf("skew_valid[%0d]", i), 64'(bus.out_valid), 64'(tbl[i].ev));
      chk($sformatf("skew_out[%0d]", i), 64'(bus.out), 64'(tbl[i].eout));
      chk($sformatf("skew_empty[%0d]", i), 64'(bus.o_empty), 64'(tbl[i].eempty));
    end

    // Fill to depth, dropped 65th write, full drain
    for (int k = 0; k < DEPTH; k++) cyc(1'b1, 1'b1, mkvec(k), 1'b0);
    chk("fill_full", 64'(bus.o_full), 64'h1);
    chk("fill_ready", 64'(bus.o_ready), 64'h0);
    cyc(1'b1, 1'b1, 32'hFFFFFFFF, 1'b0);
    chk("drop_full", 64'(bus.o_full), 64'h1);
    clr_pops();
    seen_f    = 1'b0;
    seen7     = 1'b0;
    prev_full = bus.o_full;
    for (int k = 0; k < DEPTH + ROW; k++) begin
      cyc(1'b1, 1'b0, '0, (k < DEPTH));
      if (bus.out_valid[7] && !seen7) begin
        seen7 = 1'b1;
        chk("full_before_row7_pop", 64'(prev_full), 64'h1);
        chk("full_clear_after_row7_pop", 64'(bus.o_full), 64'h0);
      end
      prev_full = bus.o_full;
    end
    chk("drain_row0_pops", 64'(pops[0]), 64'(DEPTH));
    chk("drain_row7_pops", 64'(pops[7]), 64'(DEPTH));
    chk("drain_no_f", 64'(seen_f), 64'h0);
    chk("drain_empty", 64'(bus.o_empty), 64'h1);

    // Read of empty buffer: no valid, out holds, pointers intact
    snap = bus.out;
    clr_pops();
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, '0, 1'b1);
    idle(ROW);
    chk("empty_rd_pops", 64'(pops[7]), 64'h0);
    chk("empty_rd_hold", 64'(bus.out), 64'(snap));
    cyc(1'b1, 1'b1, 32'hA9876543, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1);
    clr_pops();
    idle(ROW);
    chk("empty_rd_after_out", 64'(bus.out), 64'hA9876543);
    chk("empty_rd_after_pops", 64'(pops[7]), 64'h1);

    // Streaming with 4 preloaded entries
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, mkvec(100 + k), 1'b0);
    for (int k = 0; k < 100; k++) begin
      cyc(1'b1, 1'b1, mkvec(200 + k), 1'b1);
      chk("stream_full", 64'(bus.o_full), 64'h0);
    end
    idle(ROW);
    chk("stream_not_empty", 64'(bus.o_empty), 64'h0);
    clr_pops();
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, '0, 1'b1);
    idle(ROW);
    chk("stream_left_row0", 64'(pops[0]), 64'h4);
    chk("stream_left_row7", 64'(pops[7]), 64'h4);
    chk("stream_end_empty", 64'(bus.o_empty), 64'h1);

    // Mid-operation reset
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, mkvec(300 + k), 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("midrst_valid", 64'(bus.out_valid), 64'h0);
    chk("midrst_empty", 64'(bus.o_empty), 64'h1);
    chk("midrst_out", 64'(bus.out), 64'h0);
    clr_pops();
    idle(ROW);
    chk("midrst_no_stale", 64'(pops[7]), 64'h0);
    cyc(1'b1, 1'b1, 32'h2468ACE1, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1);
    idle(ROW);
    chk("midrst_new_out", 64'(bus.out), 64'h2468ACE1);
    chk("midrst_new_pops", 64'(pops[7]), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
